// File: rtl/conv2d_stream_engine.sv
// ---------------------------------------------------------------------------
// conv2d_stream_engine
// Streaming 3x3 signed convolution over an IMG_W x IMG_H raster frame.
// Produces the valid-mode (unpadded) result, (IMG_W-2)*(IMG_H-2) pixels per
// frame, with rounding and saturation, then pulses out_st.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   coef_we    coefficient write strobe (honoured only while not busy)
//   coef_addr  kernel index 0..8, raster order, 4 = centre
//   coef_din   signed coefficient, FRAC_BITS fractional bits
//   in_st      frame start pulse (honoured only in IDLE)
//   din_valid  pixel valid
//   din        signed pixel
//   din_ready  engine accepts a pixel this cycle
//   dout_valid result valid, 2 cycles after the accepting edge
//   dout       signed result, holds between results
//   out_st     one-cycle frame-complete pulse
//   busy       frame in progress
//
// Build option: define CONV2D_RELU_EN to clamp negative results to zero.
// ---------------------------------------------------------------------------
module conv2d_stream_engine #(
   parameter int unsigned IMG_W     = 8,
   parameter int unsigned IMG_H     = 8,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned COEF_W    = 8,
   parameter int unsigned FRAC_BITS = 7
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     coef_we,
   input  logic [3:0]               coef_addr,
   input  logic signed [COEF_W-1:0] coef_din,
   input  logic                     in_st,
   input  logic                     din_valid,
   input  logic signed [DATA_W-1:0] din,
   output logic                     din_ready,
   output logic                     dout_valid,
   output logic signed [DATA_W-1:0] dout,
   output logic                     out_st,
   output logic                     busy
);

   localparam int unsigned COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int unsigned ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int unsigned PROD_W = DATA_W + COEF_W;
   localparam int unsigned SUM_W  = PROD_W + 4;

   localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);

   localparam logic signed [SUM_W-1:0] RND     = SUM_W'(1 << (FRAC_BITS - 1));
   localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((1 << (DATA_W - 1)) - 1);
   localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_DRAIN  = 2'd2,
      S_DONE   = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [COL_W-1:0]   col_q, col_d;
   logic [ROW_W-1:0]   row_q, row_d;
   logic               drain_q, drain_d;
   logic               din_ready_q, busy_q, out_st_q;
   logic               accept_c;
   logic               emit_c;

   logic signed [COEF_W-1:0] coef_q [9];
   logic signed [DATA_W-1:0] lb0_q  [IMG_W];
   logic signed [DATA_W-1:0] lb1_q  [IMG_W];
   logic signed [DATA_W-1:0] win_q  [3][3];
   logic                     v1_q;
   logic                     dout_valid_q;
   logic signed [DATA_W-1:0] dout_q;

   logic signed [SUM_W-1:0]  sum_c;
   logic signed [SUM_W-1:0]  rnd_c;
   logic signed [SUM_W-1:0]  shr_c;
   logic signed [DATA_W-1:0] res_c;

   assign accept_c = din_valid & din_ready_q;
   // Window holds a full 3x3 neighbourhood once two rows and two columns are in
   assign emit_c   = accept_c && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

   // Next-state and counter logic
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      drain_d = drain_q;
      unique case (state_q)
         S_IDLE: begin
            if (in_st) begin
               state_d = S_STREAM;
               col_d   = '0;
               row_d   = '0;
            end
         end
         S_STREAM: begin
            if (accept_c) begin
               if (col_q == LAST_COL) begin
                  col_d = '0;
                  row_d = row_q + ROW_W'(1);
                  if (row_q == LAST_ROW) begin
                     state_d = S_DRAIN;
                     drain_d = 1'b0;
                  end
               end else begin
                  col_d = col_q + COL_W'(1);
               end
            end
         end
         S_DRAIN: begin
            // Two cycles let the final result leave the output register
            drain_d = 1'b1;
            if (drain_q) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, counters and registered status outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         col_q       <= '0;
         row_q       <= '0;
         drain_q     <= 1'b0;
         din_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         out_st_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         drain_q     <= drain_d;
         din_ready_q <= (state_d == S_STREAM);
         busy_q      <= (state_d == S_STREAM) || (state_d == S_DRAIN);
         out_st_q    <= (state_d == S_DONE);
      end
   end

   // Kernel register file; frozen while a frame is in progress
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < 9; k++) begin
            coef_q[k] <= '0;
         end
      end else if (coef_we && !busy_q && (coef_addr <= 4'd8)) begin
         coef_q[coef_addr] <= coef_din;
      end
   end

   // Stage 1: line buffers and sliding window
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(IMG_W); i++) begin
            lb0_q[i] <= '0;
            lb1_q[i] <= '0;
         end
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               win_q[r][c] <= '0;
            end
         end
         v1_q <= 1'b0;
      end else begin
         v1_q <= emit_c;
         if (accept_c) begin
            for (int r = 0; r < 3; r++) begin
               win_q[r][0] <= win_q[r][1];
               win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2]  <= lb1_q[col_q];
            win_q[1][2]  <= lb0_q[col_q];
            win_q[2][2]  <= din;
            lb1_q[col_q] <= lb0_q[col_q];
            lb0_q[col_q] <= din;
         end
      end
   end

   // Multiply-accumulate, round half up, saturate
   always_comb begin
      sum_c = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            sum_c = sum_c + SUM_W'(PROD_W'(win_q[r][c]) * PROD_W'(coef_q[r*3 + c]));
         end
      end
      rnd_c = sum_c + RND;
      shr_c = rnd_c >>> FRAC_BITS;
      if (shr_c > SAT_MAX) begin
         res_c = DATA_W'(SAT_MAX);
      end else if (shr_c < SAT_MIN) begin
         res_c = DATA_W'(SAT_MIN);
      end else begin
         res_c = DATA_W'(shr_c);
      end
`ifdef CONV2D_RELU_EN
      if (res_c[DATA_W-1]) begin
         res_c = '0;
      end
`endif
   end

   // Stage 2: result register, holds between results
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dout_valid_q <= 1'b0;
         dout_q       <= '0;
      end else begin
         dout_valid_q <= v1_q;
         if (v1_q) begin
            dout_q <= res_c;
         end
      end
   end

   assign din_ready  = din_ready_q;
   assign busy       = busy_q;
   assign out_st     = out_st_q;
   assign dout_valid = dout_valid_q;
   assign dout       = dout_q;

endmodule

// File: doc/conv2d_stream_engine.md
Name: conv2d_stream_engine

Overview:
- Streaming 3x3 2D convolution engine for signed fixed-point images of parametrised size.
- Kernel coefficients are loaded through a register port. A frame is started with in_st, and pixels are accepted in raster order through a valid/ready handshake.
- Uses two line buffers plus a 3x3 window; emits the valid-mode (unpadded) result, (IMG_W-2)x(IMG_H-2) pixels, then pulses out_st.
- Successor to the fixed 8x8/8-bit ModuleConv: adds generic size and width, runtime kernel load, rounding/saturation and a frame handshake.

Parameters:
- IMG_W, 8: pixels per row (>=3)
- IMG_H, 8: rows per frame (>=3)
- DATA_W, 8: signed pixel and result width
- COEF_W, 8: signed coefficient width
- FRAC_BITS, 7: coefficient fractional bits (>=1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- coef_we  in  1  coefficient write strobe
- coef_addr  in  4  kernel index 0..8, raster order (4 = centre)
- coef_din  in  COEF_W  signed coefficient
- in_st  in  1  frame start pulse
- din_valid  in  1  pixel valid
- din  in  DATA_W  signed pixel
- din_ready  out  1  engine accepts a pixel this cycle
- dout_valid  out  1  result valid
- dout  out  DATA_W  signed result
- out_st  out  1  one-cycle frame-complete pulse
- busy  out  1  frame in progress

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; all counters, line buffers, window and pipeline registers cleared.
  - All 9 coefficients = 0.
  - din_ready=0, dout_valid=0, dout=0, out_st=0, busy=0.
- States:
  - IDLE: in_st=1 -> STREAM; row/col counters cleared; busy=1 from the next cycle.
  - STREAM: din_ready=1. A pixel is accepted when din_valid&din_ready. col advances; at IMG_W-1 it wraps to 0 and row increments. After pixel (IMG_H-1, IMG_W-1) is accepted -> DRAIN, din_ready=0.
  - DRAIN: wait 2 cycles for the pipeline to empty -> DONE.
  - DONE: out_st=1 for one cycle, busy=0 -> IDLE.
- Gaps: din_valid=0 cycles stall input only; the pipeline still advances in-flight results.
- Window: on each accepted pixel, the 3x3 window shifts left. The new column is {linebuf1[col], linebuf0[col], din}, then linebuf1[col]<=linebuf0[col] and linebuf0[col]<=din.
- Output condition: accepted pixel with row>=2 and col>=2 produces one result.
- Latency: dout_valid=1 exactly 2 cycles after the accept edge (stage 1: window update; stage 2: MAC plus round/saturate register).
- Ordering: results in raster order; exactly (IMG_W-2)*(IMG_H-2) per frame.
- Arithmetic:
  - Products are DATA_W+COEF_W signed.
  - Sum of 9 products is DATA_W+COEF_W+4 bits, no overflow.
  - Add 2^(FRAC_BITS-1), arithmetic shift right FRAC_BITS (floor).
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- dout holds its last value when dout_valid=0.
- Coefficient writes: applied when coef_we=1 and busy=0. Ignored while busy or when coef_addr>8.
- in_st while busy or in DONE: ignored.
- Reset mid-frame: immediate abort to the reset state. No out_st is issued, and coefficients are lost.
- Simultaneous coef_we and in_st in IDLE: the write takes effect, and the frame uses the new coefficient.

Optional Feature:
- Macro: CONV2D_RELU_EN.
- Defined: after saturation, negative results are replaced by 0.
- Undefined: signed saturated result passed unchanged.
- Latency is identical in both builds.

Test Plan:
- Centre gain: coef[4]=64, others 0; 8x8 frame of constant 100, din_valid held high -> 36 results of 50. First dout_valid 2 cycles after pixel (2,2) is accepted; out_st one cycle after the DRAIN completes; busy low afterwards.
- Rounding and sign: coef[4]=64; all pixels -100 -> every dout = -50. All 9 coef=16 and pixels 100 -> dout = 113.
- Saturation: all coef=127, pixels 127 -> dout = 127. All coef=-127, pixels 127 -> dout = -128, or 0 with CONV2D_RELU_EN.
- Spatial correctness: coef[0]=64 (top-left tap), others 0; pixel(r,c)=r*8+c -> result k (k=0..35, window top-left (r0,c0)=(k/6,k%6)) equals (r0*8+c0)/2 rounded, i.e. first dout=0, then 1, 1, 2, ...
- Handshake gaps and ignores:
  - din_valid toggled 1,0 every cycle -> same 36 values as with continuous input; out_st exactly once.
  - coef_we mid-frame -> no change to results.
  - in_st mid-frame -> ignored.
- Reset abort: assert reset after 20 pixels -> outputs 0 immediately. A fresh frame after reload of coefficients gives correct results and no stale window data.
